// File: rtl/hub75_init_injector.sv
// rtl/hub75_init_injector.sv - one-shot FM6126A register injection ahead of the HUB75 PHY
module hub75_init_injector #(
    parameter int          N_BANKS = 2,
    parameter int          N_ROWS  = 32,
    parameter int          N_COLS  = 64,
    parameter int          N_CHANS = 3,
    parameter logic [15:0] INIT_R1 = 16'h7FFF,
    parameter logic [15:0] INIT_R2 = 16'h0040
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         phy_in_addr_inc,
    input  logic                         phy_in_addr_rst,
    input  logic [$clog2(N_ROWS)-1:0]    phy_in_addr,
    input  logic [N_BANKS*N_CHANS-1:0]   phy_in_data,
    input  logic                         phy_in_clk,
    input  logic                         phy_in_le,
    input  logic                         phy_in_blank,
    output logic                         phy_out_addr_inc,
    output logic                         phy_out_addr_rst,
    output logic [$clog2(N_ROWS)-1:0]    phy_out_addr,
    output logic [N_BANKS*N_CHANS-1:0]   phy_out_data,
    output logic                         phy_out_clk,
    output logic                         phy_out_le,
    output logic                         phy_out_blank,
    input  logic                         scan_go_in,
    output logic                         scan_go_out,
    input  logic                         scan_rdy_in,
    output logic                         scan_rdy_out,
    input  logic                         bcm_rdy_in
);

    localparam int DW       = N_BANKS * N_CHANS;
    localparam int AW       = $clog2(N_ROWS);
    localparam int CW       = $clog2(N_COLS);
    localparam int LE1_TAIL = 11;
    localparam int LE2_TAIL = 12;
    localparam int GAP_LEN  = 4;

    typedef enum logic [2:0] {
        WAIT = 3'd0,
        REG1 = 3'd1,
        GAP1 = 3'd2,
        REG2 = 3'd3,
        GAP2 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            clk_q;
    logic            le_q;
    logic [DW-1:0]   data_q;

    // Register bits are sent MSB-first, the 16-bit word repeating across the row.
    function automatic logic [DW-1:0] col_data(input logic [15:0] r, input logic [CW-1:0] c);
        logic [3:0] idx;
        idx = 4'((N_COLS - 1) - 32'(c));
        return {DW{r[idx]}};
    endfunction

    // LE is held for the last 'tail' columns; the tail length selects the register.
    function automatic logic col_le(input logic [CW-1:0] c, input int tail);
        return 32'(c) >= 32'(N_COLS - tail);
    endfunction

    // Sequencer: output registers are loaded with the values for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            le_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (scan_rdy_in && bcm_rdy_in) begin
                        state_q <= REG1;
                        cnt_q   <= '0;
                        clk_q   <= 1'b1;
                        le_q    <= col_le('0, LE1_TAIL);
                        data_q  <= col_data(INIT_R1, '0);
                    end
                end
                REG1: begin
                    if (cnt_q == CW'(N_COLS - 1)) begin
                        state_q <= GAP1;
                        cnt_q   <= '0;
                        clk_q   <= 1'b0;
                        le_q    <= 1'b0;
                        data_q  <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        le_q    <= col_le(cnt_q + 1'b1, LE1_TAIL);
                        data_q  <= col_data(INIT_R1, cnt_q + 1'b1);
                    end
                end
                GAP1: begin
                    if (cnt_q == CW'(GAP_LEN - 1)) begin
                        state_q <= REG2;
                        cnt_q   <= '0;
                        clk_q   <= 1'b1;
                        le_q    <= col_le('0, LE2_TAIL);
                        data_q  <= col_data(INIT_R2, '0);
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                REG2: begin
                    if (cnt_q == CW'(N_COLS - 1)) begin
                        state_q <= GAP2;
                        cnt_q   <= '0;
                        clk_q   <= 1'b0;
                        le_q    <= 1'b0;
                        data_q  <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        le_q    <= col_le(cnt_q + 1'b1, LE2_TAIL);
                        data_q  <= col_data(INIT_R2, cnt_q + 1'b1);
                    end
                end
                GAP2: begin
                    if (cnt_q == CW'(GAP_LEN - 1)) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    // Output mux: transparent once done, otherwise the injector owns the bus and blanks the panel.
    always_comb begin
        if (state_q == DONE) begin
            phy_out_addr_inc = phy_in_addr_inc;
            phy_out_addr_rst = phy_in_addr_rst;
            phy_out_addr     = phy_in_addr;
            phy_out_data     = phy_in_data;
            phy_out_clk      = phy_in_clk;
            phy_out_le       = phy_in_le;
            phy_out_blank    = phy_in_blank;
            scan_go_out      = scan_go_in;
            scan_rdy_out     = scan_rdy_in;
        end else begin
            phy_out_addr_inc = 1'b0;
            phy_out_addr_rst = 1'b0;
            phy_out_addr     = '0;
            phy_out_data     = data_q;
            phy_out_clk      = clk_q;
            phy_out_le       = le_q;
            phy_out_blank    = 1'b1;
            scan_go_out      = 1'b0;
            scan_rdy_out     = 1'b0;
        end
    end

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;

endmodule

// File: tb/tb_hub75_init_injector.sv
// tb/tb_hub75_init_injector.sv - randomized bench for hub75_init_injector against a timeline model
module tb_hub75_init_injector;

    localparam int NC      = 64;
    localparam int SEQ_LEN = 2 * NC + 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       phy_in_addr_inc, phy_in_addr_rst;
    logic [4:0] phy_in_addr;
    logic [5:0] phy_in_data;
    logic       phy_in_clk, phy_in_le, phy_in_blank;
    logic       phy_out_addr_inc, phy_out_addr_rst;
    logic [4:0] phy_out_addr;
    logic [5:0] phy_out_data;
    logic       phy_out_clk, phy_out_le, phy_out_blank;
    logic       scan_go_in, scan_go_out, scan_rdy_in, scan_rdy_out, bcm_rdy_in;

    hub75_init_injector dut (
        .clk              (clk),
        .rst              (rst),
        .phy_in_addr_inc  (phy_in_addr_inc),
        .phy_in_addr_rst  (phy_in_addr_rst),
        .phy_in_addr      (phy_in_addr),
        .phy_in_data      (phy_in_data),
        .phy_in_clk       (phy_in_clk),
        .phy_in_le        (phy_in_le),
        .phy_in_blank     (phy_in_blank),
        .phy_out_addr_inc (phy_out_addr_inc),
        .phy_out_addr_rst (phy_out_addr_rst),
        .phy_out_addr     (phy_out_addr),
        .phy_out_data     (phy_out_data),
        .phy_out_clk      (phy_out_clk),
        .phy_out_le       (phy_out_le),
        .phy_out_blank    (phy_out_blank),
        .scan_go_in       (scan_go_in),
        .scan_go_out      (scan_go_out),
        .scan_rdy_in      (scan_rdy_in),
        .scan_rdy_out     (scan_rdy_out),
        .bcm_rdy_in       (bcm_rdy_in)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          t     = -1;
    bit          valid = 1'b0;
    logic [15:0] r1    = 16'h7FFF;
    logic [15:0] r2    = 16'h0040;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 50)
                $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the timeline, advance the model at posedge.
    task automatic step(input bit rst_v, input bit rnd_rdy, input bit bcm_hold,
                        input bit loop_go, input bit directed);
        logic       e_clk, e_le, bit_v, chk_data;
        logic [5:0] e_data;
        int         c;
        @(negedge clk);
        rst             = rst_v;
        phy_in_addr_inc = 1'($urandom);
        phy_in_addr_rst = 1'($urandom);
        phy_in_addr     = 5'($urandom);
        phy_in_data     = 6'($urandom);
        phy_in_clk      = 1'($urandom);
        phy_in_le       = 1'($urandom);
        phy_in_blank    = 1'($urandom);
        scan_go_in      = 1'($urandom);
        scan_rdy_in     = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        bcm_rdy_in      = bcm_hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (directed) begin
            phy_in_data  = 6'h2A;
            phy_in_addr  = 5'h13;
            phy_in_blank = 1'b0;
            scan_rdy_in  = 1'b1;
            scan_go_in   = 1'b1;
        end
        #1;
        if (loop_go) scan_go_in = scan_rdy_out;
        #1;
        if (valid) begin
            if (t >= SEQ_LEN) begin
                check("addr_inc", 32'(phy_out_addr_inc), 32'(phy_in_addr_inc));
                check("addr_rst", 32'(phy_out_addr_rst), 32'(phy_in_addr_rst));
                check("addr",     32'(phy_out_addr),     32'(phy_in_addr));
                check("data",     32'(phy_out_data),     32'(phy_in_data));
                check("clk",      32'(phy_out_clk),      32'(phy_in_clk));
                check("le",       32'(phy_out_le),       32'(phy_in_le));
                check("blank",    32'(phy_out_blank),    32'(phy_in_blank));
                check("rdy_out",  32'(scan_rdy_out),     32'(scan_rdy_in));
                check("go_out",   32'(scan_go_out),      32'(loop_go ? scan_rdy_in : scan_go_in));
            end else begin
                e_clk = 1'b0; e_le = 1'b0; e_data = '0; chk_data = 1'b1;
                if (t >= 0 && t < NC) begin
                    c = t;
                    bit_v = r1[(NC - 1 - c) % 16];
                    e_clk = 1'b1; e_le = (c >= NC - 11); e_data = {6{bit_v}};
                end else if (t >= NC + 4 && t < 2 * NC + 4) begin
                    c = t - (NC + 4);
                    bit_v = r2[(NC - 1 - c) % 16];
                    e_clk = 1'b1; e_le = (c >= NC - 12); e_data = {6{bit_v}};
                end else if (t >= 0) begin
                    chk_data = 1'b0;
                end
                check("addr_inc", 32'(phy_out_addr_inc), 32'd0);
                check("addr_rst", 32'(phy_out_addr_rst), 32'd0);
                check("addr",     32'(phy_out_addr),     32'd0);
                if (chk_data) check("data", 32'(phy_out_data), 32'(e_data));
                check("clk",      32'(phy_out_clk),      32'(e_clk));
                check("le",       32'(phy_out_le),       32'(e_le));
                check("blank",    32'(phy_out_blank),    32'd1);
                check("rdy_out",  32'(scan_rdy_out),     32'd0);
                check("go_out",   32'(scan_go_out),      32'd0);
            end
        end
        @(posedge clk);
        if (rst) begin
            t = -1;
            valid = 1'b1;
        end else if (valid) begin
            if (t < 0) begin
                if (scan_rdy_in && bcm_rdy_in) t = 0;
            end else if (t < SEQ_LEN) begin
                t++;
            end
        end
    endtask

    initial begin
        // Reset, then hold the BCM busy for 50 cycles.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (SEQ_LEN + 4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset mid-REG2 with go looped back from rdy, then a full rerun.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (100) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (200) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // Random soak with occasional resets.
        repeat (2500) step(($urandom_range(0, 399) == 0), 1'b1, 1'b0, 1'($urandom), 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
